// File: rtl/opcode_fetch.sv
// Fetches big-endian 16-bit opcodes as two byte reads from program memory and
// presents them to the decoder with a valid/ready handshake.
// Optional OPCODE_FETCH_ALIGN_CHECK_EN adds a sticky align_err output.
module opcode_fetch #(
  parameter logic [11:0] RESET_PC = 12'h200
) (
  input  logic        clk,
  input  logic        rst,
  output logic [11:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_data,
  output logic [15:0] opcode,
  output logic        opcode_valid,
  input  logic        opcode_ready,
  output logic [11:0] pc,
  input  logic        pc_load,
  input  logic [11:0] pc_load_addr,
  input  logic        skip
`ifdef OPCODE_FETCH_ALIGN_CHECK_EN
  ,
  output logic        align_err
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HI,
    S_LO,
    S_CAP,
    S_VALID
  } state_t;

  state_t      state_q, state_d;
  logic [11:0] pc_q, pc_d;
  logic [15:0] opcode_q, opcode_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      opcode_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      opcode_q <= opcode_d;
    end
  end

  // Read data returns one cycle after the strobe, so each byte is captured
  // in the state following the one that issued its read.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    opcode_d = opcode_q;
    mem_rd   = 1'b0;
    mem_addr = pc_q;
    case (state_q)
      S_IDLE: state_d = S_HI;
      S_HI: begin
        mem_rd  = 1'b1;
        state_d = S_LO;
      end
      S_LO: begin
        mem_rd         = 1'b1;
        mem_addr       = pc_q + 12'd1;
        opcode_d[15:8] = mem_data;
        state_d        = S_CAP;
      end
      S_CAP: begin
        opcode_d[7:0] = mem_data;
        state_d       = S_VALID;
      end
      S_VALID: begin
        if (opcode_ready) begin
          state_d = S_HI;
          if (pc_load)   pc_d = pc_load_addr;
          else if (skip) pc_d = pc_q + 12'd4;
          else           pc_d = pc_q + 12'd2;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign opcode       = opcode_q;
  assign pc           = pc_q;
  assign opcode_valid = (state_q == S_VALID);

`ifdef OPCODE_FETCH_ALIGN_CHECK_EN
  logic align_q;

  always_ff @(posedge clk) begin
    if (rst)                             align_q <= 1'b0;
    else if (state_q == S_CAP && pc_q[0]) align_q <= 1'b1;
  end

  assign align_err = align_q;
`endif

endmodule
